sdram_arbiter: RTL and testbench

- Upstream neighbour of the embedded SDRAM controller (`ram`). It multiplexes two clients onto that controller's single read/write request interface.
  - Video fetcher: burst reads only.
  - CPU port: single-word read/write.
- Sequences the controller's pulse-style requests and counts read beats to detect completion.
- Enforces a guard gap so no new request reaches the controller while it is still in its precharge tail.

---
 rtl/sdram_pkg.sv | 29 ++
 rtl/sdram_arbiter.sv | 265 ++++++++++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared widths, FSM encodings and client id for the SDRAM front-end arbiter.
package sdram_pkg;

   localparam int ADDR_WIDTH  = 23;
   localparam int DATA_WIDTH  = 32;
   localparam int BURST_WIDTH = 9;
   localparam int MASK_WIDTH  = 4;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_RD_ISSUE = 3'd1;
   localparam state_t ST_RD_DATA  = 3'd2;
   localparam state_t ST_WR_ISSUE = 3'd3;
   localparam state_t ST_WR_WAIT  = 3'd4;
   localparam state_t ST_GUARD    = 3'd5;

   typedef enum logic {
      CLIENT_CPU = 1'b0,
      CLIENT_VID = 1'b1
   } client_e;

   function automatic logic [BURST_WIDTH-1:0] clamp_burst(
      input logic [BURST_WIDTH-1:0] len,
      input logic [BURST_WIDTH-1:0] max_len);
      return (len > max_len) ? max_len : len;
   endfunction

endpackage

// File: rtl/sdram_arbiter.sv
// Two-client (video burst reader, CPU single word) front end for the SDRAM controller.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | arbitrate vid_req / cpu_req, latch the winner's request
// RD_ISSUE  | ram_rd_request pulse
// RD_DATA   | count rd_available beats until the latched length
// WR_ISSUE  | ram_wr_request pulse (CPU write)
// WR_WAIT   | wait for ram_wr_done
// GUARD     | cover controller precharge tail, requests ignored
module sdram_arbiter
   import sdram_pkg::*;
#(
   parameter int GUARD_CYCLES   = 4,
   parameter int MAX_BURST      = 256,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   vid_req,
   input  logic [ADDR_WIDTH-1:0]  vid_address,
   input  logic [BURST_WIDTH-1:0] vid_burst_length,
   output logic                   vid_data_valid,
   output logic [DATA_WIDTH-1:0]  vid_data,
   output logic                   vid_done,
   input  logic                   cpu_req,
   input  logic                   cpu_we,
   input  logic [ADDR_WIDTH-1:0]  cpu_address,
   input  logic [DATA_WIDTH-1:0]  cpu_wdata,
   input  logic [MASK_WIDTH-1:0]  cpu_mask,
   output logic [DATA_WIDTH-1:0]  cpu_rdata,
   output logic                   cpu_done,
   output logic                   ram_rd_request,
   output logic [ADDR_WIDTH-1:0]  ram_rd_address,
   output logic [BURST_WIDTH-1:0] ram_rd_burst_length,
   input  logic                   ram_rd_available,
   input  logic [DATA_WIDTH-1:0]  ram_rd_data,
   output logic                   ram_wr_request,
   input  logic                   ram_wr_done,
   output logic [MASK_WIDTH-1:0]  ram_wr_mask,
   output logic [ADDR_WIDTH-1:0]  ram_wr_address,
   output logic [DATA_WIDTH-1:0]  ram_wr_data,
   output logic [BURST_WIDTH-1:0] ram_wr_burst_length,
   output logic                   error
);

   localparam int GW  = $clog2(GUARD_CYCLES + 1);
   localparam int WDW = $clog2(TIMEOUT_CYCLES) + 1;

   localparam logic [GW-1:0]          GUARD_LOAD = GW'(GUARD_CYCLES - 1);
   localparam logic [WDW-1:0]         WD_LOAD    = WDW'(TIMEOUT_CYCLES - 1);
   localparam logic [BURST_WIDTH-1:0] MAX_LEN    = BURST_WIDTH'(MAX_BURST);

   state_t                   state_q, state_d;
   client_e                  last_q, last_d;
   client_e                  client_q, client_d;
   logic [BURST_WIDTH-1:0]   len_q, len_d;
   logic [BURST_WIDTH-1:0]   beat_q, beat_d;
   logic [GW-1:0]            guard_q, guard_d;
   logic [WDW-1:0]           wd_q, wd_d;
   logic                     error_q, error_d;
   logic                     vid_dv_q, vid_dv_d;
   logic [DATA_WIDTH-1:0]    vid_data_q, vid_data_d;
   logic                     vid_done_q, vid_done_d;
   logic [DATA_WIDTH-1:0]    cpu_rdata_q, cpu_rdata_d;
   logic                     cpu_done_q, cpu_done_d;
   logic                     rd_req_q, rd_req_d;
   logic [ADDR_WIDTH-1:0]    rd_addr_q, rd_addr_d;
   logic [BURST_WIDTH-1:0]   rd_len_q, rd_len_d;
   logic                     wr_req_q, wr_req_d;
   logic [ADDR_WIDTH-1:0]    wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
   logic [MASK_WIDTH-1:0]    wr_mask_q, wr_mask_d;

   logic                     grant_vid;
   logic                     grant_cpu;
   logic [BURST_WIDTH-1:0]   vid_len_clamped;

   // Round-robin only matters when both ask; a lone requester always wins.
   assign grant_vid       = vid_req && (!cpu_req || (last_q == CLIENT_CPU));
   assign grant_cpu       = cpu_req && !grant_vid;
   assign vid_len_clamped = clamp_burst(vid_burst_length, MAX_LEN);

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      client_d    = client_q;
      len_d       = len_q;
      beat_d      = beat_q;
      guard_d     = guard_q;
      wd_d        = wd_q;
      error_d     = error_q;
      vid_dv_d    = 1'b0;
      vid_data_d  = vid_data_q;
      vid_done_d  = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      cpu_done_d  = 1'b0;
      rd_req_d    = 1'b0;
      rd_addr_d   = rd_addr_q;
      rd_len_d    = rd_len_q;
      wr_req_d    = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      wr_mask_d   = wr_mask_q;

      case (state_q)
         ST_IDLE: begin
            beat_d = '0;
            if (grant_vid) begin
               last_d    = CLIENT_VID;
               client_d  = CLIENT_VID;
               len_d     = vid_len_clamped;
               if (vid_burst_length == '0) begin
                  vid_done_d = 1'b1;
                  guard_d    = GUARD_LOAD;
                  state_d    = ST_GUARD;
               end else begin
                  rd_addr_d = vid_address;
                  rd_len_d  = vid_len_clamped;
                  rd_req_d  = 1'b1;
                  state_d   = ST_RD_ISSUE;
               end
            end else if (grant_cpu) begin
               last_d   = CLIENT_CPU;
               client_d = CLIENT_CPU;
               if (cpu_we) begin
                  wr_addr_d = cpu_address;
                  wr_data_d = cpu_wdata;
                  wr_mask_d = cpu_mask;
                  wr_req_d  = 1'b1;
                  state_d   = ST_WR_ISSUE;
               end else begin
                  len_d     = BURST_WIDTH'(1);
                  rd_addr_d = cpu_address;
                  rd_len_d  = BURST_WIDTH'(1);
                  rd_req_d  = 1'b1;
                  state_d   = ST_RD_ISSUE;
               end
            end
         end

         ST_RD_ISSUE: begin
            wd_d    = WD_LOAD;
            state_d = ST_RD_DATA;
         end

         ST_RD_DATA: begin
            if (ram_rd_available) begin
               beat_d = beat_q + BURST_WIDTH'(1);
               if (client_q == CLIENT_VID) begin
                  vid_dv_d   = 1'b1;
                  vid_data_d = ram_rd_data;
               end
            end
            if (ram_rd_available && ((beat_q + BURST_WIDTH'(1)) == len_q)) begin
               if (client_q == CLIENT_VID) begin
                  vid_done_d = 1'b1;
               end else begin
                  cpu_done_d  = 1'b1;
                  cpu_rdata_d = ram_rd_data;
               end
               guard_d = GUARD_LOAD;
               state_d = ST_GUARD;
            end else if (wd_q == '0) begin
               error_d    = 1'b1;
               vid_done_d = (client_q == CLIENT_VID);
               cpu_done_d = (client_q == CLIENT_CPU);
               guard_d    = GUARD_LOAD;
               state_d    = ST_GUARD;
            end else begin
               wd_d = wd_q - WDW'(1);
            end
         end

         ST_WR_ISSUE: begin
            wd_d    = WD_LOAD;
            state_d = ST_WR_WAIT;
         end

         ST_WR_WAIT: begin
            if (ram_wr_done) begin
               cpu_done_d = 1'b1;
               guard_d    = GUARD_LOAD;
               state_d    = ST_GUARD;
            end else if (wd_q == '0) begin
               error_d    = 1'b1;
               cpu_done_d = 1'b1;
               guard_d    = GUARD_LOAD;
               state_d    = ST_GUARD;
            end else begin
               wd_d = wd_q - WDW'(1);
            end
         end

         ST_GUARD: begin
            if (guard_q == '0) state_d = ST_IDLE;
            else               guard_d = guard_q - GW'(1);
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         last_q      <= CLIENT_CPU;
         client_q    <= CLIENT_CPU;
         len_q       <= '0;
         beat_q      <= '0;
         guard_q     <= '0;
         wd_q        <= '0;
         error_q     <= 1'b0;
         vid_dv_q    <= 1'b0;
         vid_data_q  <= '0;
         vid_done_q  <= 1'b0;
         cpu_rdata_q <= '0;
         cpu_done_q  <= 1'b0;
         rd_req_q    <= 1'b0;
         rd_addr_q   <= '0;
         rd_len_q    <= '0;
         wr_req_q    <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         wr_mask_q   <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         client_q    <= client_d;
         len_q       <= len_d;
         beat_q      <= beat_d;
         guard_q     <= guard_d;
         wd_q        <= wd_d;
         error_q     <= error_d;
         vid_dv_q    <= vid_dv_d;
         vid_data_q  <= vid_data_d;
         vid_done_q  <= vid_done_d;
         cpu_rdata_q <= cpu_rdata_d;
         cpu_done_q  <= cpu_done_d;
         rd_req_q    <= rd_req_d;
         rd_addr_q   <= rd_addr_d;
         rd_len_q    <= rd_len_d;
         wr_req_q    <= wr_req_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         wr_mask_q   <= wr_mask_d;
      end
   end

   assign vid_data_valid      = vid_dv_q;
   assign vid_data            = vid_data_q;
   assign vid_done            = vid_done_q;
   assign cpu_rdata           = cpu_rdata_q;
   assign cpu_done            = cpu_done_q;
   assign ram_rd_request      = rd_req_q;
   assign ram_rd_address      = rd_addr_q;
   assign ram_rd_burst_length = rd_len_q;
   assign ram_wr_request      = wr_req_q;
   assign ram_wr_address      = wr_addr_q;
   assign ram_wr_data         = wr_data_q;
   assign ram_wr_mask         = wr_mask_q;
   assign ram_wr_burst_length = BURST_WIDTH'(1);
   assign error               = error_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a small SDRAM controller model.
module tb_sdram_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        vid_req;
   logic [22:0] vid_address;
   logic [8:0]  vid_burst_length;
   logic        vid_data_valid;
   logic [31:0] vid_data;
   logic        vid_done;
   logic        cpu_req;
   logic        cpu_we;
   logic [22:0] cpu_address;
   logic [31:0] cpu_wdata;
   logic [3:0]  cpu_mask;
   logic [31:0] cpu_rdata;
   logic        cpu_done;
   logic        ram_rd_request;
   logic [22:0] ram_rd_address;
   logic [8:0]  ram_rd_burst_length;
   logic        ram_rd_available;
   logic [31:0] ram_rd_data;
   logic        ram_wr_request;
   logic        ram_wr_done;
   logic [3:0]  ram_wr_mask;
   logic [22:0] ram_wr_address;
   logic [31:0] ram_wr_data;
   logic [8:0]  ram_wr_burst_length;
   logic        error;

   sdram_arbiter dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .vid_req             (vid_req),
      .vid_address         (vid_address),
      .vid_burst_length    (vid_burst_length),
      .vid_data_valid      (vid_data_valid),
      .vid_data            (vid_data),
      .vid_done            (vid_done),
      .cpu_req             (cpu_req),
      .cpu_we              (cpu_we),
      .cpu_address         (cpu_address),
      .cpu_wdata           (cpu_wdata),
      .cpu_mask            (cpu_mask),
      .cpu_rdata           (cpu_rdata),
      .cpu_done            (cpu_done),
      .ram_rd_request      (ram_rd_request),
      .ram_rd_address      (ram_rd_address),
      .ram_rd_burst_length (ram_rd_burst_length),
      .ram_rd_available    (ram_rd_available),
      .ram_rd_data         (ram_rd_data),
      .ram_wr_request      (ram_wr_request),
      .ram_wr_done         (ram_wr_done),
      .ram_wr_mask         (ram_wr_mask),
      .ram_wr_address      (ram_wr_address),
      .ram_wr_data         (ram_wr_data),
      .ram_wr_burst_length (ram_wr_burst_length),
      .error               (error)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mdl_word(input logic [22:0] a, input int i);
      return 32'hC0DE_0000 + {9'd0, a} + 32'(i);
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Controller model: reads return data 2 cycles after the request, writes ack after 3.
   bit mdl_mute = 1'b0;
   int wr_done_cyc = 0;

   initial begin
      ram_rd_available = 1'b0;
      ram_rd_data      = '0;
      ram_wr_done      = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && ram_wr_request) begin
            repeat (3) @(posedge clk);
            #1;
            ram_wr_done = 1'b1;
            wr_done_cyc = cyc;
            @(posedge clk);
            #1;
            ram_wr_done = 1'b0;
         end else if (rst_n && ram_rd_request && !mdl_mute) begin
            int          n;
            logic [22:0] a;
            n = int'(ram_rd_burst_length);
            a = ram_rd_address;
            repeat (2) @(posedge clk);
            #1;
            for (int i = 0; i < n; i++) begin
               if (!rst_n) break;
               ram_rd_available = 1'b1;
               ram_rd_data      = mdl_word(a, i);
               @(posedge clk);
               #1;
            end
            ram_rd_available = 1'b0;
            ram_rd_data      = '0;
         end
      end
   end

   // Output monitor, sampled on the falling edge.
   logic [31:0] vbuf [0:511];
   int          vcnt = 0;
   int          vid_done_cnt = 0, cpu_done_cnt = 0;
   int          vid_done_cyc = 0, cpu_done_cyc = 0;
   bit          vid_done_with_valid = 1'b0;
   logic [31:0] cpu_rdata_seen = '0;
   int          rd_req_cnt = 0, rd_req_cyc = 0, wr_req_cnt = 0, wr_req_cyc = 0;
   logic [22:0] rd_addr_seen = '0, wr_addr_seen = '0;
   logic [8:0]  rd_len_seen = '0, wr_len_seen = '0;
   logic [31:0] wr_data_seen = '0;
   logic [3:0]  wr_mask_seen = '0;
   bit          rd_prev = 1'b0, wr_prev = 1'b0, req_long = 1'b0;

   initial forever begin
      @(negedge clk);
      if (vid_data_valid) begin
         if (vcnt < 512) vbuf[vcnt] = vid_data;
         vcnt++;
      end
      if (vid_done) begin
         vid_done_cnt++;
         vid_done_cyc        = cyc;
         vid_done_with_valid = vid_data_valid;
      end
      if (cpu_done) begin
         cpu_done_cnt++;
         cpu_done_cyc   = cyc;
         cpu_rdata_seen = cpu_rdata;
      end
      if (ram_rd_request) begin
         rd_req_cnt++;
         rd_req_cyc   = cyc;
         rd_addr_seen = ram_rd_address;
         rd_len_seen  = ram_rd_burst_length;
         if (rd_prev) req_long = 1'b1;
      end
      if (ram_wr_request) begin
         wr_req_cnt++;
         wr_req_cyc   = cyc;
         wr_addr_seen = ram_wr_address;
         wr_data_seen = ram_wr_data;
         wr_mask_seen = ram_wr_mask;
         wr_len_seen  = ram_wr_burst_length;
         if (wr_prev) req_long = 1'b1;
      end
      rd_prev = ram_rd_request;
      wr_prev = ram_wr_request;
   end

   int raise_cyc = 0;

   // Call just after a rising edge; returns just after the edge following done.
   task automatic run_vid(input logic [22:0] a, input logic [8:0] len, input int budget);
      bit ok = 1'b0;
      vid_address      = a;
      vid_burst_length = len;
      vid_req          = 1'b1;
      raise_cyc        = cyc;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (vid_done) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      vid_req = 1'b0;
      if (!ok) chk("vid_done_wait", 32'd0, 32'd1);
   endtask

   task automatic run_cpu(input logic we, input logic [22:0] a, input logic [31:0] d,
                          input logic [3:0] m, input int budget);
      bit ok = 1'b0;
      cpu_we      = we;
      cpu_address = a;
      cpu_wdata   = d;
      cpu_mask    = m;
      cpu_req     = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (cpu_done) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
      if (!ok) chk("cpu_done_wait", 32'd0, 32'd1);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int    cnt0;
      int    dcnt_v, dcnt_c;
      byte   who;
      bit    ok;

      rst_n            = 1'b0;
      vid_req          = 1'b0;
      vid_address      = '0;
      vid_burst_length = '0;
      cpu_req          = 1'b0;
      cpu_we           = 1'b0;
      cpu_address      = '0;
      cpu_wdata        = '0;
      cpu_mask         = '0;

      // Reset values
      repeat (3) @(posedge clk);
      #2;
      chk("rst_vid_valid", 32'(vid_data_valid), 32'd0);
      chk("rst_vid_done", 32'(vid_done), 32'd0);
      chk("rst_cpu_done", 32'(cpu_done), 32'd0);
      chk("rst_rd_req", 32'(ram_rd_request), 32'd0);
      chk("rst_wr_req", 32'(ram_wr_request), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_wr_burst", 32'(ram_wr_burst_length), 32'd1);
      chk("rst_rd_burst", 32'(ram_rd_burst_length), 32'd0);
      rst_n = 1'b1;
      idle_cycles(2);

      // Video burst of 8 followed immediately by a CPU write
      vcnt = 0;
      run_vid(23'h000400, 9'd8, 100);
      chk("vid8_count", 32'(vcnt), 32'd8);
      for (int i = 0; i < 8; i++) chk("vid8_beat", vbuf[i], mdl_word(23'h000400, i));
      chk("vid8_done_with_last", 32'(vid_done_with_valid), 32'd1);
      chk("vid8_rd_len", 32'(rd_len_seen), 32'd8);
      chk("vid8_rd_addr", 32'(rd_addr_seen), 32'h000400);
      run_cpu(1'b1, 23'h000010, 32'hDEADBEEF, 4'b0011, 100);
      chk("guard_gap", 32'(wr_req_cyc - vid_done_cyc), 32'd5);
      chk("wr_addr", 32'(wr_addr_seen), 32'h000010);
      chk("wr_data", wr_data_seen, 32'hDEADBEEF);
      chk("wr_mask", 32'(wr_mask_seen), 32'h3);
      chk("wr_burst", 32'(wr_len_seen), 32'd1);
      chk("wr_done_to_cpu_done", 32'(cpu_done_cyc - wr_done_cyc), 32'd1);

      // Video length 0: no RAM access, done next cycle
      idle_cycles(10);
      cnt0 = rd_req_cnt;
      vcnt = 0;
      run_vid(23'h000200, 9'd0, 20);
      chk("len0_done_latency", 32'(vid_done_cyc - raise_cyc), 32'd1);
      chk("len0_no_rd_req", 32'(rd_req_cnt - cnt0), 32'd0);
      chk("len0_no_data", 32'(vcnt), 32'd0);

      // Video length 300 clamps to 256
      idle_cycles(10);
      vcnt = 0;
      run_vid(23'h001000, 9'd300, 400);
      chk("clamp_rd_len", 32'(rd_len_seen), 32'd256);
      chk("clamp_count", 32'(vcnt), 32'd256);
      chk("clamp_last_beat", vbuf[255], mdl_word(23'h001000, 255));

      // Both requesting for 4 operations; last grant was video
      idle_cycles(10);
      cpu_we           = 1'b1;
      cpu_address      = 23'h000020;
      cpu_wdata        = 32'h12345678;
      cpu_mask         = 4'hF;
      vid_address      = 23'h000800;
      vid_burst_length = 9'd2;
      vid_req          = 1'b1;
      cpu_req          = 1'b1;
      for (int k = 0; k < 4; k++) begin
         who = "-";
         for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (vid_done) begin who = "V"; break; end
            if (cpu_done) begin who = "C"; break; end
         end
         chk("rr_grant", 32'(who), (k % 2 == 0) ? 32'("C") : 32'("V"));
         @(posedge clk);
         #1;
         if (k == 3) begin
            vid_req = 1'b0;
            cpu_req = 1'b0;
         end else begin
            if (who == "V") vid_req = 1'b0;
            else            cpu_req = 1'b0;
            @(posedge clk);
            #1;
            vid_req = 1'b1;
            cpu_req = 1'b1;
         end
      end

      // Watchdog: controller never returns data
      idle_cycles(10);
      mdl_mute = 1'b1;
      vcnt     = 0;
      run_vid(23'h002000, 9'd4, 1200);
      chk("wd_error", 32'(error), 32'd1);
      chk("wd_done_time", 32'(vid_done_cyc - rd_req_cyc), 32'd1025);
      chk("wd_no_data", 32'(vcnt), 32'd0);
      mdl_mute = 1'b0;
      idle_cycles(10);
      run_cpu(1'b0, 23'h001234, 32'h0, 4'h0, 100);
      chk("post_wd_rdata", cpu_rdata_seen, mdl_word(23'h001234, 0));
      chk("post_wd_rd_len", 32'(rd_len_seen), 32'd1);
      chk("error_sticky", 32'(error), 32'd1);

      // Reset in the middle of a video burst
      idle_cycles(10);
      vcnt             = 0;
      vid_address      = 23'h003000;
      vid_burst_length = 9'd16;
      vid_req          = 1'b1;
      ok               = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (vcnt >= 4) begin ok = 1'b1; break; end
      end
      chk("mid_burst_reached", 32'(ok), 32'd1);
      dcnt_v = vid_done_cnt;
      dcnt_c = cpu_done_cnt;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_vid_valid", 32'(vid_data_valid), 32'd0);
      chk("async_vid_data", vid_data, 32'd0);
      chk("async_rd_addr", 32'(ram_rd_address), 32'd0);
      chk("async_rd_len", 32'(ram_rd_burst_length), 32'd0);
      chk("async_error", 32'(error), 32'd0);
      chk("async_wr_burst", 32'(ram_wr_burst_length), 32'd1);
      vid_req = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idle_cycles(6);
      chk("rst_no_vid_done", 32'(vid_done_cnt - dcnt_v), 32'd0);
      chk("rst_no_cpu_done", 32'(cpu_done_cnt - dcnt_c), 32'd0);
      run_cpu(1'b0, 23'h7FFFFF, 32'h0, 4'h0, 100);
      chk("post_rst_rd_addr", 32'(rd_addr_seen), 32'h7FFFFF);
      chk("post_rst_rdata", cpu_rdata_seen, mdl_word(23'h7FFFFF, 0));
      chk("req_single_cycle", 32'(req_long), 32'd0);

      idle_cycles(5);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench time limit");
   end

endmodule
